instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter IMEM_WORDS, default 64: instruction memory depth in 32-bit words (power of two).
REQ-002 Parameter RESET_PC, default 64'h0: PC value loaded by reset.
REQ-003 Reset is asynchronous and active-high; single clock.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  async active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins or resumes execution.
REQ-007 prog_we  input  1  instruction memory write enable.
REQ-008 prog_addr  input  log2(IMEM_WORDS)  word address for programming.
REQ-009 prog_data  input  32  instruction word to write.
REQ-010 Uncondbranch  input  1  from main control; B taken.
REQ-011 Branch  input  1  from main control; CBZ-type conditional branch.
REQ-012 Zero  input  1  ALU zero flag for the current instruction.
REQ-013 PC  output  64  current program counter.
REQ-014 Instruct  output  32  current instruction, feeds main control decode.
REQ-015 running  output  1  high in RUN state.
REQ-016 halted  output  1  high in HALT state.
REQ-017 instr_count  output  16  retired-instruction counter.

Function
REQ-018 FSM states IDLE, RUN, HALT; reset enters IDLE.
REQ-019 Instruct SHALL be combinational: imem[PC[log2(IMEM_WORDS)+1:2]]; PC[1:0] ignored; upper PC bits alias (wrap).
REQ-020 imem write: synchronous, on rising edge when prog_we=1 and state is IDLE or HALT; prog_we in RUN ignored.
REQ-021 imem contents not affected by reset.
REQ-022 IDLE: PC held; start=1 -> RUN next edge.
REQ-023 RUN, Instruct != 0: PC <= next_pc each edge; instr_count += 1, saturating at 16'hFFFF.
REQ-024 next_pc priority: Uncondbranch=1 -> PC + (sext64(Instruct[25:0]) << 2); else Branch=1 and Zero=1 -> PC + (sext64(Instruct[23:5]) << 2); else PC + 4.
REQ-025 All PC arithmetic modulo 2^64; no overflow detection.
REQ-026 RUN, Instruct == 32'h0: -> HALT next edge; PC and instr_count held (halt word not retired).
REQ-027 HALT: PC held; start=1 -> RUN next edge, resuming at held PC (re-fetches halt word unless reprogrammed).
REQ-028 start in RUN ignored.
REQ-029 IDLE/HALT with start=1 and prog_we=1 same edge: write and state change both occur; first RUN cycle sees new word.
REQ-030 Uncondbranch/Branch/Zero ignored outside RUN.
REQ-031 Branch to own address (offset 0) legal: PC stays constant, instr_count keeps incrementing.
REQ-032 running = (state==RUN); halted = (state==HALT); both registered-state decodes, glitch-free.

Reset
REQ-033 On reset assertion, immediately (no clock): state=IDLE, PC=RESET_PC, instr_count=0, running=0, halted=0.
REQ-034 Reset mid-RUN aborts execution; no imem write or PC update on the edge where reset is high.
REQ-035 After deassertion, block remains IDLE until start.

Verification
REQ-036 Sequential: program words 0-2 = 32'h8B000000 (ADD), 32'h8A000000, 32'h0; start -> PC 0,4,8 on successive cycles, then halted=1, PC=8, instr_count=2.
REQ-037 Unconditional: word0 = 32'h14000003 (B +3), Uncondbranch=1 -> PC 0 -> 12; word = 32'h17FFFFFF (B -1) at 12 -> PC 8.
REQ-038 CBZ: word0 = 32'hB4000040 (imm19=2); Branch=1,Zero=1 -> PC 8; Branch=1,Zero=0 -> PC 4.
REQ-039 Wrap: IMEM_WORDS=64, B to PC 256 -> Instruct equals imem[0]; PC reads 256.
REQ-040 Reset mid-RUN at PC=20 with prog_we=1 -> PC=0, IDLE, instr_count=0 without clock; imem word unchanged; prog_we during RUN leaves memory unchanged.
REQ-041 HALT resume: reprogram halt word to ADD while halted, pulse start -> PC advances +4, instr_count increments.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: program counter sequencing with branch target selection,
// plus a programmable instruction memory gated by an IDLE/RUN/HALT controller.
module instr_fetch #(
  parameter int          IMEM_WORDS = 64,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          Uncondbranch,
  input  logic                          Branch,
  input  logic                          Zero,
  output logic [63:0]                   PC,
  output logic [31:0]                   Instruct,
  output logic                          running,
  output logic                          halted,
  output logic [15:0]                   instr_count
);

  // state | meaning
  // IDLE  | out of reset; PC held, imem programmable, waits for start
  // RUN   | fetching; PC advances once per non-zero instruction
  // HALT  | all-zero word fetched; PC held, imem programmable, start resumes

  localparam int AW = $clog2(IMEM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] imem_q [IMEM_WORDS];

  logic [63:0] uncond_off;
  logic [63:0] cbz_off;
  logic [63:0] next_pc;
  logic        halt_word;
  logic        imem_we;

  // Upper PC bits alias onto the memory, so the index is just the low word bits.
  assign Instruct    = imem_q[pc_q[AW+1:2]];
  assign halt_word   = (Instruct == 32'h0);
  assign PC          = pc_q;
  assign instr_count = cnt_q;
  assign running     = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign imem_we     = prog_we && (state_q != RUN);

  always_comb begin
    uncond_off = {{36{Instruct[25]}}, Instruct[25:0], 2'b00};
    cbz_off    = {{43{Instruct[23]}}, Instruct[23:5], 2'b00};
    if (Uncondbranch) begin
      next_pc = pc_q + uncond_off;
    end else if (Branch && Zero) begin
      next_pc = pc_q + cbz_off;
    end else begin
      next_pc = pc_q + 64'd4;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (halt_word) begin
          state_d = HALT;
        end else begin
          pc_d = next_pc;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end
      end
      HALT: begin
        if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory keeps its contents through reset; a write is only suppressed while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (!reset && imem_we) begin
      imem_q[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: randomized and directed stimulus, expected
// state from a behavioural model, checked by an independent monitor each cycle.
module tb_instr_fetch;

  localparam int          IMEM_WORDS = 64;
  localparam int          AW         = 6;
  localparam logic [63:0] RESET_PC   = 64'h0;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;
  localparam logic [31:0] ADD_W = 32'h8B000000;

  logic          clk;
  logic          reset;
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          Uncondbranch;
  logic          Branch;
  logic          Zero;
  logic [63:0]   PC;
  logic [31:0]   Instruct;
  logic          running;
  logic          halted;
  logic [15:0]   instr_count;

  instr_fetch #(.IMEM_WORDS(IMEM_WORDS), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .Uncondbranch(Uncondbranch), .Branch(Branch), .Zero(Zero),
    .PC(PC), .Instruct(Instruct), .running(running), .halted(halted),
    .instr_count(instr_count)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        run;
    logic        hlt;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  logic [31:0] m_mem [IMEM_WORDS];
  logic [63:0] m_pc;
  logic [15:0] m_cnt;
  int          m_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int widx(input logic [63:0] pc);
    return int'((pc >> 2) % IMEM_WORDS);
  endfunction

  // Monitor: one expectation per driven cycle, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", PC, e.pc);
      chk("instr", {32'h0, Instruct}, {32'h0, e.ins});
      chk("running", {63'h0, running}, {63'h0, e.run});
      chk("halted", {63'h0, halted}, {63'h0, e.hlt});
      chk("count", {48'h0, instr_count}, {48'h0, e.cnt});
    end
  end

  task automatic drive(input bit st, input bit we, input int wa, input logic [31:0] wd,
                       input bit ub, input bit br, input bit z);
    logic [31:0] ins;
    longint      off;
    exp_t        e;
    @(negedge clk);
    start = st; prog_we = we; prog_addr = AW'(wa); prog_data = wd;
    Uncondbranch = ub; Branch = br; Zero = z;
    ins = m_mem[widx(m_pc)];
    if (we && m_state != S_RUN) m_mem[wa % IMEM_WORDS] = wd;
    case (m_state)
      S_IDLE, S_HALT: if (st) m_state = S_RUN;
      default: begin
        if (ins == 32'h0) begin
          m_state = S_HALT;
        end else begin
          if (ub) begin
            off  = $signed(ins[25:0]);
            m_pc = m_pc + off * 4;
          end else if (br && z) begin
            off  = $signed(ins[23:5]);
            m_pc = m_pc + off * 4;
          end else begin
            m_pc = m_pc + 4;
          end
          if (m_cnt < 16'hFFFF) m_cnt = m_cnt + 1;
        end
      end
    endcase
    e.pc  = m_pc;
    e.ins = m_mem[widx(m_pc)];
    e.run = (m_state == S_RUN);
    e.hlt = (m_state == S_HALT);
    e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic prog(input int wa, input logic [31:0] wd);
    drive(1'b0, 1'b1, wa, wd, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle_step(input bit ub, input bit br, input bit z);
    drive(1'b0, 1'b0, 0, 32'h0, ub, br, z);
  endtask

  task automatic do_reset(input bit we, input int wa, input logic [31:0] wd);
    @(negedge clk);
    #2;
    start = 1'b0; Uncondbranch = 1'b0; Branch = 1'b0; Zero = 1'b0;
    prog_we = we; prog_addr = AW'(wa); prog_data = wd;
    reset = 1'b1;
    #1;
    m_state = S_IDLE; m_pc = RESET_PC; m_cnt = 16'h0;
    chk("rst_pc", PC, RESET_PC);
    chk("rst_count", {48'h0, instr_count}, 64'h0);
    chk("rst_running", {63'h0, running}, 64'h0);
    chk("rst_halted", {63'h0, halted}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; prog_we = 1'b0;
    #1;
    chk("rst_instr", {32'h0, Instruct}, {32'h0, m_mem[widx(m_pc)]});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    Uncondbranch = 1'b0; Branch = 1'b0; Zero = 1'b0;
    m_state = S_IDLE; m_pc = RESET_PC; m_cnt = 16'h0;
    for (int i = 0; i < IMEM_WORDS; i++) m_mem[i] = 32'h0;
    #3;
    chk("init_pc", PC, RESET_PC);
    chk("init_running", {63'h0, running}, 64'h0);
    chk("init_halted", {63'h0, halted}, 64'h0);
    chk("init_count", {48'h0, instr_count}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < IMEM_WORDS; i++) prog(i, 32'h0);

    // Sequential run into a halt word.
    do_reset(1'b0, 0, 32'h0);
    prog(0, ADD_W); prog(1, 32'h8A000000); prog(2, 32'h0);
    drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) idle_step(1'b0, 1'b0, 1'b0);
    #2;
    chk("seq_pc", PC, 64'd8);
    chk("seq_halted", {63'h0, halted}, 64'h1);
    chk("seq_count", {48'h0, instr_count}, 64'd2);

    // Unconditional branches forward and backward.
    do_reset(1'b0, 0, 32'h0);
    prog(0, 32'h14000003); prog(3, 32'h17FFFFFF);
    drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_step(1'b1, 1'b0, 1'b0);
    #2 chk("b_fwd_pc", PC, 64'd12);
    idle_step(1'b1, 1'b0, 1'b0);
    #2 chk("b_back_pc", PC, 64'd8);
    idle_step(1'b0, 1'b0, 1'b0);

    // CBZ taken and not taken.
    do_reset(1'b0, 0, 32'h0);
    prog(0, 32'hB4000040);
    drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_step(1'b0, 1'b1, 1'b1);
    #2 chk("cbz_taken_pc", PC, 64'd8);
    do_reset(1'b0, 0, 32'h0);
    drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_step(1'b0, 1'b1, 1'b0);
    #2 chk("cbz_nottaken_pc", PC, 64'd4);

    // Branch past the end of memory aliases back to word 0.
    do_reset(1'b0, 0, 32'h0);
    prog(0, 32'h14000040);
    drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle_step(1'b1, 1'b0, 1'b0);
    #2;
    chk("wrap_pc", PC, 64'd256);
    chk("wrap_instr", {32'h0, Instruct}, 64'h14000040);

    // Reset mid-run with a write attempt, then halt/resume with reprogramming.
    do_reset(1'b0, 0, 32'h0);
    for (int i = 0; i < 6; i++) prog(i, ADD_W);
    prog(6, 32'h0); prog(7, 32'h0);
    drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) idle_step(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
    #2 chk("mid_pc", PC, 64'd20);
    do_reset(1'b1, 0, 32'h12345678);
    chk("rst_keep_word0", {32'h0, Instruct}, {32'h0, ADD_W});
    drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (7) idle_step(1'b0, 1'b0, 1'b0);
    #2;
    chk("halt_pc", PC, 64'd24);
    chk("halt_count", {48'h0, instr_count}, 64'd6);
    drive(1'b1, 1'b1, 6, ADD_W, 1'b0, 1'b0, 1'b0);
    idle_step(1'b0, 1'b0, 1'b0);
    #2;
    chk("resume_pc", PC, 64'd28);
    chk("resume_count", {48'h0, instr_count}, 64'd7);

    // Randomized traffic.
    do_reset(1'b0, 0, 32'h0);
    for (int i = 0; i < IMEM_WORDS; i++)
      prog(i, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom());
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(0, 1) == 1, $urandom_range(0, IMEM_WORDS - 1), $urandom());
      end else begin
        drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, IMEM_WORDS - 1),
              ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom(),
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1);
      end
    end

    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
